// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: bundles the three requester ports and the external
// memory port of memory_arbiter.
//   master : the arbiter side (drives memory strobes and completion pulses)
//   slave  : the environment side (requesters and the memory device)
interface memory_arbiter_if;
  // Requester protocol: *_address_enable is a level request, held until the
  // matching one-cycle *_data_valid completion pulse. Memory protocol: a
  // strobe (mem_read/mem_write) is accepted on the first edge where
  // mem_wait_request is low; read data arrives later with mem_read_data_valid.
  logic        fetch_address_enable;
  logic [31:0] fetch_address;
  logic [31:0] fetch_data;
  logic        fetch_data_valid;

  logic        read_address_enable;
  logic [31:0] read_address;
  logic [31:0] read_data;
  logic        read_data_valid;

  logic        write_address_enable;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic        write_data_valid;

  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic        mem_wait_request;
  logic [31:0] mem_read_data;
  logic        mem_read_data_valid;

  logic        timeout_error;

  modport master (
    input  fetch_address_enable, fetch_address,
    input  read_address_enable, read_address,
    input  write_address_enable, write_address, write_data,
    input  mem_wait_request, mem_read_data, mem_read_data_valid,
    output fetch_data, fetch_data_valid,
    output read_data, read_data_valid,
    output write_data_valid,
    output mem_address, mem_read, mem_write, mem_write_data,
    output timeout_error
  );

  modport slave (
    output fetch_address_enable, fetch_address,
    output read_address_enable, read_address,
    output write_address_enable, write_address, write_data,
    output mem_wait_request, mem_read_data, mem_read_data_valid,
    input  fetch_data, fetch_data_valid,
    input  read_data, read_data_valid,
    input  write_data_valid,
    input  mem_address, mem_read, mem_write, mem_write_data,
    input  timeout_error
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one external memory port between fetch, read-stage
// and write-stage requesters, one transaction at a time, with a read watchdog.
// Optional macro MEMORY_ARBITER_ROUND_ROBIN_EN selects round-robin arbitration
// (fetch -> read -> write -> fetch); without it, fixed priority write > read > fetch.
// debug_state encoding: 0 Idle, 1 Issue, 2 Wait, 3 Respond.
module memory_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clock,
  input  logic               reset,
  memory_arbiter_if.master   bus,
  output logic [1:0]         debug_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  localparam logic [1:0] ID_FETCH = 2'd0;
  localparam logic [1:0] ID_READ  = 2'd1;
  localparam logic [1:0] ID_WRITE = 2'd2;
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t      state;
  logic [1:0]  grant_id;
  logic [7:0]  wd_count;
  logic        win_valid;
  logic [1:0]  win_id;
  logic        read_done;
  logic        timeout_hit;
  logic [31:0] resp_data;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  // Requester with first claim on the next grant.
  logic [1:0]  rr_ptr;
`endif

  assign debug_state = state;

  // Pick the winner among the current requests (only acted on in Idle).
  always_comb begin
    win_valid = bus.fetch_address_enable | bus.read_address_enable |
                bus.write_address_enable;
    win_id    = ID_FETCH;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    case (rr_ptr)
      ID_READ:
        if (bus.read_address_enable)       win_id = ID_READ;
        else if (bus.write_address_enable) win_id = ID_WRITE;
        else                               win_id = ID_FETCH;
      ID_WRITE:
        if (bus.write_address_enable)      win_id = ID_WRITE;
        else if (bus.fetch_address_enable) win_id = ID_FETCH;
        else                               win_id = ID_READ;
      default:
        if (bus.fetch_address_enable)      win_id = ID_FETCH;
        else if (bus.read_address_enable)  win_id = ID_READ;
        else                               win_id = ID_WRITE;
    endcase
`else
    if (bus.write_address_enable)     win_id = ID_WRITE;
    else if (bus.read_address_enable) win_id = ID_READ;
    else                              win_id = ID_FETCH;
`endif
  end

  // Read completion in Wait: real data wins over a watchdog expiry in the same cycle.
  always_comb begin
    read_done   = bus.mem_read_data_valid;
    timeout_hit = !bus.mem_read_data_valid && (wd_count + 8'd1 == TIMEOUT_LIMIT);
    resp_data   = bus.mem_read_data_valid ? bus.mem_read_data : 32'h0;
  end

  // Transaction FSM with all bus outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                <= IDLE;
      grant_id             <= ID_FETCH;
      wd_count             <= 8'd0;
      bus.mem_address      <= 32'h0;
      bus.mem_write_data   <= 32'h0;
      bus.mem_read         <= 1'b0;
      bus.mem_write        <= 1'b0;
      bus.fetch_data       <= 32'h0;
      bus.fetch_data_valid <= 1'b0;
      bus.read_data        <= 32'h0;
      bus.read_data_valid  <= 1'b0;
      bus.write_data_valid <= 1'b0;
      bus.timeout_error    <= 1'b0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      rr_ptr               <= ID_FETCH;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            grant_id <= win_id;
            state    <= ISSUE;
            case (win_id)
              ID_WRITE: begin
                bus.mem_address    <= bus.write_address;
                bus.mem_write_data <= bus.write_data;
                bus.mem_write      <= 1'b1;
              end
              ID_READ: begin
                bus.mem_address <= bus.read_address;
                bus.mem_read    <= 1'b1;
              end
              default: begin
                bus.mem_address <= bus.fetch_address;
                bus.mem_read    <= 1'b1;
              end
            endcase
          end
        end
        ISSUE: begin
          // Strobe, address and data stay put while the memory stalls.
          if (!bus.mem_wait_request) begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            if (grant_id == ID_WRITE) begin
              bus.write_data_valid <= 1'b1;
              state                <= RESPOND;
            end else begin
              wd_count <= 8'd0;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (read_done || timeout_hit) begin
            if (grant_id == ID_READ) begin
              bus.read_data       <= resp_data;
              bus.read_data_valid <= 1'b1;
            end else begin
              bus.fetch_data       <= resp_data;
              bus.fetch_data_valid <= 1'b1;
            end
            if (timeout_hit) bus.timeout_error <= 1'b1;
            state <= RESPOND;
          end else begin
            wd_count <= wd_count + 8'd1;
          end
        end
        RESPOND: begin
          bus.fetch_data_valid <= 1'b0;
          bus.read_data_valid  <= 1'b0;
          bus.write_data_valid <= 1'b0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
          rr_ptr <= (grant_id == ID_WRITE) ? ID_FETCH : grant_id + 2'd1;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed tests for memory_arbiter with a behavioural
// memory, requester driver tasks and a completion scoreboard.
`timescale 1ns/1ps
module tb_memory_arbiter;

  localparam int unsigned TIMEOUT = 4;
  localparam logic [1:0] ID_FETCH = 2'd0;
  localparam logic [1:0] ID_READ  = 2'd1;
  localparam logic [1:0] ID_WRITE = 2'd2;

  logic       clock;
  logic       reset;
  logic [1:0] debug_state;

  memory_arbiter_if bus();

  memory_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus.master),
    .debug_state (debug_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  // Scoreboard entries: {requester id, completion data}; write completions carry 0.
  logic [33:0] exp_q[$];

  // Memory model controls (written by the stimulus process only).
  int cfg_stall   = 0;
  int cfg_latency = 1;
  bit cfg_drop    = 1'b0;
  int inject_req  = 0;
  // Written by the memory model only.
  int read_strobes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic [1:0] id, input logic en,
                         input logic [31:0] addr, input logic [31:0] wdata);
    case (id)
      ID_WRITE: begin
        bus.write_address_enable = en;
        bus.write_address        = addr;
        bus.write_data           = wdata;
      end
      ID_READ: begin
        bus.read_address_enable = en;
        bus.read_address        = addr;
      end
      default: begin
        bus.fetch_address_enable = en;
        bus.fetch_address        = addr;
      end
    endcase
  endtask

  // Holds the request until its completion pulse, then drops it in the next cycle.
  task automatic do_req(input logic [1:0] id, input logic [31:0] addr, input logic [31:0] wdata);
    bit seen;
    seen = 1'b0;
    set_req(id, 1'b1, addr, wdata);
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clock);
      case (id)
        ID_WRITE: seen = bus.write_data_valid;
        ID_READ:  seen = bus.read_data_valid;
        default:  seen = bus.fetch_data_valid;
      endcase
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: id %0d got no completion, expected one", id);
    end
    @(posedge clock);
    #1;
    set_req(id, 1'b0, addr, wdata);
  endtask

  // ---------------- memory model ----------------
  initial begin : mem_model
    logic [31:0] mem_array [logic [31:0]];
    bit          in_txn;
    bit          pending;
    bit          prev_read;
    int          stall_left;
    int          lat_left;
    int          inject_seen;
    logic [31:0] rd_addr;
    mem_array[32'h100] = 32'hDEADBEEF;
    in_txn = 1'b0; pending = 1'b0; prev_read = 1'b0;
    stall_left = 0; lat_left = 0; inject_seen = 0; rd_addr = 32'h0;
    bus.mem_wait_request    = 1'b0;
    bus.mem_read_data       = 32'h0;
    bus.mem_read_data_valid = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      bus.mem_read_data_valid = 1'b0;
      if (inject_req != inject_seen) begin
        inject_seen             = inject_req;
        bus.mem_read_data       = 32'h7777_7777;
        bus.mem_read_data_valid = 1'b1;
      end
      if (reset) begin
        in_txn = 1'b0; pending = 1'b0; prev_read = 1'b0;
        bus.mem_wait_request = 1'b0;
      end else begin
        if (bus.mem_read && !prev_read) read_strobes++;
        prev_read = bus.mem_read;
        if (pending) begin
          lat_left--;
          if (lat_left == 0) begin
            pending                 = 1'b0;
            bus.mem_read_data       = mem_array.exists(rd_addr) ? mem_array[rd_addr] : 32'hFFFF_FFFF;
            bus.mem_read_data_valid = 1'b1;
          end
        end
        if ((bus.mem_read || bus.mem_write) && !in_txn) begin
          in_txn     = 1'b1;
          stall_left = cfg_stall;
        end
        if (in_txn) begin
          if (stall_left > 0) begin
            bus.mem_wait_request = 1'b1;
            stall_left--;
          end else begin
            bus.mem_wait_request = 1'b0;
            in_txn = 1'b0;
            if (bus.mem_write) begin
              mem_array[bus.mem_address] = bus.mem_write_data;
            end else if (!cfg_drop) begin
              pending  = 1'b1;
              lat_left = cfg_latency;
              rd_addr  = bus.mem_address;
            end
          end
        end else begin
          bus.mem_wait_request = 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [33:0] act;
    logic [33:0] exp;
    int          nvalid;
    forever begin
      @(negedge clock);
      nvalid = int'(bus.fetch_data_valid) + int'(bus.read_data_valid) + int'(bus.write_data_valid);
      if (nvalid > 1) check("single_valid", 64'(nvalid), 64'd1);
      if (nvalid > 0) begin
        if (bus.write_data_valid)     act = {ID_WRITE, 32'h0};
        else if (bus.read_data_valid) act = {ID_READ, bus.read_data};
        else                          act = {ID_FETCH, bus.fetch_data};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: got %0h expected none", act);
        end else begin
          exp = exp_q.pop_front();
          check("completion", 64'(act), 64'(exp));
        end
      end
    end
  end

  // ---------------- global time bound ----------------
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    int strobe_snap;
    reset = 1'b1;
    set_req(ID_FETCH, 1'b0, 32'h0, 32'h0);
    set_req(ID_READ,  1'b0, 32'h0, 32'h0);
    set_req(ID_WRITE, 1'b0, 32'h0, 32'h0);
    cyc(3);

    // Reset values
    check("rst_state",       debug_state, 2'd0);
    check("rst_mem_read",    bus.mem_read, 1'b0);
    check("rst_mem_write",   bus.mem_write, 1'b0);
    check("rst_mem_address", bus.mem_address, 32'h0);
    check("rst_mem_wdata",   bus.mem_write_data, 32'h0);
    check("rst_valids",      {bus.fetch_data_valid, bus.read_data_valid, bus.write_data_valid}, 3'b000);
    check("rst_data",        {bus.fetch_data, bus.read_data}, 64'h0);
    check("rst_timeout",     bus.timeout_error, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Single fetch, L=2: mem_read in cycle 1, fetch_data_valid in cycle 4
    cfg_stall = 0; cfg_latency = 2; cfg_drop = 1'b0;
    exp_q.push_back({ID_FETCH, 32'hDEADBEEF});
    fork
      do_req(ID_FETCH, 32'h100, 32'h0);
      begin
        @(negedge clock);
        check("t1_c0_no_read", bus.mem_read, 1'b0);
        @(negedge clock);
        check("t1_c1_mem_read", bus.mem_read, 1'b1);
        check("t1_c1_addr", bus.mem_address, 32'h100);
        @(negedge clock);
        check("t1_c2_no_valid", bus.fetch_data_valid, 1'b0);
        @(negedge clock);
        check("t1_c3_no_valid", bus.fetch_data_valid, 1'b0);
        @(negedge clock);
        check("t1_c4_valid", bus.fetch_data_valid, 1'b1);
      end
    join

    // Store with 3 wait-request cycles: mem_write held 4 cycles, then the pulse
    cfg_stall = 3; cfg_latency = 1;
    exp_q.push_back({ID_WRITE, 32'h0});
    fork
      do_req(ID_WRITE, 32'h2000, 32'h12345678);
      begin
        @(negedge clock);
        for (int c = 1; c <= 4; c++) begin
          @(negedge clock);
          check("t2_mem_write", bus.mem_write, 1'b1);
          check("t2_addr", bus.mem_address, 32'h2000);
          check("t2_wdata", bus.mem_write_data, 32'h12345678);
        end
        @(negedge clock);
        check("t2_write_valid", bus.write_data_valid, 1'b1);
        check("t2_strobe_off", bus.mem_write, 1'b0);
      end
    join

    // Read back the store through fetch (also leaves fetch as the last grant)
    cfg_stall = 0; cfg_latency = 1;
    exp_q.push_back({ID_FETCH, 32'h12345678});
    do_req(ID_FETCH, 32'h2000, 32'h0);

    // Three simultaneous requests
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    exp_q.push_back({ID_READ,  32'hDEADBEEF});
    exp_q.push_back({ID_WRITE, 32'h0});
    exp_q.push_back({ID_FETCH, 32'h12345678});
`else
    exp_q.push_back({ID_WRITE, 32'h0});
    exp_q.push_back({ID_READ,  32'hDEADBEEF});
    exp_q.push_back({ID_FETCH, 32'h12345678});
`endif
    fork
      do_req(ID_WRITE, 32'h3000, 32'h55AA55AA);
      do_req(ID_READ,  32'h100,  32'h0);
      do_req(ID_FETCH, 32'h2000, 32'h0);
    join

    // Watchdog: no read data, TIMEOUT=4 -> completion with 0, sticky flag
    check("t4_timeout_before", bus.timeout_error, 1'b0);
    cfg_drop = 1'b1;
    exp_q.push_back({ID_READ, 32'h0});
    do_req(ID_READ, 32'h40, 32'h0);
    check("t4_timeout_set", bus.timeout_error, 1'b1);
    inject_req++;
    cyc(4);
    check("t4_timeout_sticky", bus.timeout_error, 1'b1);
    check("t4_idle_after_stale", debug_state, 2'd0);
    @(posedge clock);
    #1;

    // Reset while in Wait aborts with no completion
    set_req(ID_READ, 1'b1, 32'h44, 32'h0);
    @(negedge clock);
    @(negedge clock);
    check("t5_c1_mem_read", bus.mem_read, 1'b1);
    @(negedge clock);
    check("t5_in_wait", debug_state, 2'd2);
    @(posedge clock);
    #1;
    reset = 1'b1;
    set_req(ID_READ, 1'b0, 32'h44, 32'h0);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("t5_state_idle", debug_state, 2'd0);
    check("t5_strobes", {bus.mem_read, bus.mem_write}, 2'b00);
    check("t5_valids", {bus.fetch_data_valid, bus.read_data_valid, bus.write_data_valid}, 3'b000);
    check("t5_addr_cleared", bus.mem_address, 32'h0);
    check("t5_timeout_cleared", bus.timeout_error, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    inject_req++;
    cyc(4);
    @(posedge clock);
    #1;

    // Request held through Respond, dropped in Idle: exactly one memory read
    cfg_drop = 1'b0;
    strobe_snap = read_strobes;
    exp_q.push_back({ID_READ, 32'hDEADBEEF});
    do_req(ID_READ, 32'h100, 32'h0);
    cyc(6);
    check("t6_single_strobe", 64'(read_strobes - strobe_snap), 64'd1);
    check("t6_idle", debug_state, 2'd0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
